tag_alloc_arbiter: RTL and testbench

- Shares the free-tag FIFO of the dispatcher between N dispatch requesters (round-robin) and serialises tag returns from two CDB ports into the FIFO's single push port.
- Sits between the dispatch queues/register status table and the free-tag FIFO.
- Tracks outstanding (allocated, not yet returned) tags and flags return errors.

---
 rtl/tag_alloc_arbiter.sv | 140 ++++++++++++++
 tb/tb_tag_alloc_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_alloc_arbiter.sv
// Round-robin free-tag allocation for N dispatch requesters, plus a
// two-port tag-return skid buffer feeding the free-tag FIFO push port.
module tag_alloc_arbiter #(
  parameter int NREQ      = 4,
  parameter int TAG_W     = 6,
  parameter int NTAGS     = 64,
  parameter int RET_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic             alloc_valid,
  output logic [NREQ-1:0]  alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             fifo_pull,
  input  logic [TAG_W-1:0] fifo_tag,
  input  logic             fifo_empty,
  output logic             fifo_push,
  output logic [TAG_W-1:0] fifo_push_tag,
  input  logic             fifo_full,
  input  logic [1:0]       ret_valid,
  input  logic [TAG_W-1:0] ret_tag0,
  input  logic [TAG_W-1:0] ret_tag1,
  output logic             ret_ready,
  output logic [6:0]       outstanding,
  output logic             ret_err
);

  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(RET_DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   rr_next;
  logic [NREQ-1:0] inflight;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] win_oh;
  logic            pend_valid;
  logic            found;
  logic            pull;

  always_comb begin
    int j;
    j        = 0;
    found    = 1'b0;
    win_idx  = '0;
    eligible = req & ~inflight;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && eligible[j]) begin
        found   = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  assign win_oh  = NREQ'(1) << win_idx;
  assign rr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  // rst gates the pull so every output reads 0 while reset is held
  assign pull    = ~rst & found & ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      inflight   <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= pull;
      pending    <= pull ? win_oh : '0;
      inflight   <= pull ? win_oh : '0;
      if (pull) rr_ptr <= rr_next;
    end
  end

  assign fifo_pull   = pull;
  assign alloc_valid = pend_valid;
  assign alloc_grant = pending;
  assign alloc_tag   = pend_valid ? fifo_tag : '0;

  logic [TAG_W-1:0] mem [RET_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             acc0;
  logic             acc1;
  logic             drop;
  logic             push;
  logic [1:0]       n_acc;
  logic [7:0]       sum;
  logic [6:0]       out_n;
  logic             uflow;

  assign acc0  = ret_valid[0] & ret_ready;
  assign acc1  = ret_valid[1] & ret_ready;
  assign drop  = (|ret_valid) & ~ret_ready;
  assign n_acc = {1'b0, acc0} + {1'b0, acc1};
  assign push  = (count != '0) & ~fifo_full;

  assign count_n = count + CW'(n_acc) - CW'(push);

  always_comb begin
    sum   = {1'b0, outstanding} + {7'b0, pull};
    out_n = '0;
    uflow = 1'b0;
    if (sum >= {6'b0, n_acc}) out_n = 7'(sum - {6'b0, n_acc});
    else uflow = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr] <= ret_tag0;
    if (acc1) mem[wr_ptr + AW'(acc0)] <= ret_tag1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      ret_ready   <= 1'b0;
      outstanding <= '0;
      ret_err     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(n_acc);
      rd_ptr      <= rd_ptr + AW'(push);
      count       <= count_n;
      ret_ready   <= (count_n <= CW'(RET_DEPTH - 2));
      outstanding <= out_n;
      ret_err     <= ret_err | drop | uflow;
    end
  end

  assign fifo_push     = push;
  assign fifo_push_tag = push ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_tag_alloc_arbiter.sv
// Randomised and directed bench for tag_alloc_arbiter with a free-tag
// FIFO environment and a queue-based reference model.
module tb_tag_alloc_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       alloc_valid;
  logic [3:0] alloc_grant;
  logic [5:0] alloc_tag;
  logic       fifo_pull;
  logic [5:0] fifo_tag;
  logic       fifo_empty;
  logic       fifo_push;
  logic [5:0] fifo_push_tag;
  logic       fifo_full;
  logic [1:0] ret_valid = '0;
  logic [5:0] ret_tag0 = '0;
  logic [5:0] ret_tag1 = '0;
  logic       ret_ready;
  logic [6:0] outstanding;
  logic       ret_err;

  logic       force_full = 1'b0;
  logic       fq_full;
  logic [5:0] fq[$];

  int n_chk = 0;
  int n_pass = 0;

  int         rr;
  int         out;
  logic [3:0] pend;
  logic [3:0] blocked;
  logic [5:0] pend_tag;
  bit         err;
  bit         rdy;
  logic [5:0] rbuf[$];

  tag_alloc_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .alloc_valid(alloc_valid), .alloc_grant(alloc_grant),
    .alloc_tag(alloc_tag), .fifo_pull(fifo_pull),
    .fifo_tag(fifo_tag), .fifo_empty(fifo_empty),
    .fifo_push(fifo_push), .fifo_push_tag(fifo_push_tag),
    .fifo_full(fifo_full), .ret_valid(ret_valid),
    .ret_tag0(ret_tag0), .ret_tag1(ret_tag1),
    .ret_ready(ret_ready), .outstanding(outstanding),
    .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  assign fifo_full = force_full | fq_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      for (int i = 0; i < 64; i++) fq.push_back(6'(i));
      fifo_tag   <= '0;
      fifo_empty <= 1'b0;
      fq_full    <= 1'b1;
    end else begin
      if (fifo_pull && fq.size() > 0) fifo_tag <= fq.pop_front();
      if (fifo_push) fq.push_back(fifo_push_tag);
      fifo_empty <= (fq.size() == 0);
      fq_full    <= (fq.size() >= 64);
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_init();
    rr = 0; out = 0; pend = '0; blocked = '0;
    pend_tag = '0; err = 0; rdy = 0;
    rbuf.delete();
  endtask

  task automatic model_step();
    logic [3:0] elig;
    bit empty, full, xp, xpush;
    int w, k;
    elig  = req & ~blocked;
    empty = (fq.size() == 0);
    full  = force_full || (fq.size() >= 64);
    xp    = (elig != 0) && !empty;
    w     = -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (rr + i) % 4;
      if (w < 0 && elig[j]) w = j;
    end
    xpush = (rbuf.size() > 0) && !full;
    chk("pull", 32'(fifo_pull), 32'(xp));
    chk("alloc_valid", 32'(alloc_valid), 32'(pend != 0));
    chk("grant", 32'(alloc_grant), 32'(pend));
    if (pend != 0) chk("alloc_tag", 32'(alloc_tag), 32'(pend_tag));
    chk("push", 32'(fifo_push), 32'(xpush));
    if (xpush) chk("push_tag", 32'(fifo_push_tag), 32'(rbuf[0]));
    chk("ret_ready", 32'(ret_ready), 32'(rdy));
    chk("outstanding", 32'(outstanding), out);
    chk("ret_err", 32'(ret_err), 32'(err));
    if (xpush) void'(rbuf.pop_front());
    k = 0;
    if (ret_valid[0]) begin
      if (rdy) begin rbuf.push_back(ret_tag0); k++; end
      else err = 1;
    end
    if (ret_valid[1]) begin
      if (rdy) begin rbuf.push_back(ret_tag1); k++; end
      else err = 1;
    end
    if (out + int'(xp) < k) begin
      out = 0;
      err = 1;
    end else begin
      out = out + int'(xp) - k;
    end
    rdy = (rbuf.size() <= 2);
    if (xp) begin
      pend     = 4'(1 << w);
      pend_tag = fq[0];
      rr       = (w + 1) % 4;
    end else begin
      pend = '0;
    end
    blocked = pend;
  endtask

  task automatic run_cycle();
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, 32'(alloc_valid), 0);
    chk({tag, "_grant"}, 32'(alloc_grant), 0);
    chk({tag, "_atag"}, 32'(alloc_tag), 0);
    chk({tag, "_pull"}, 32'(fifo_pull), 0);
    chk({tag, "_push"}, 32'(fifo_push), 0);
    chk({tag, "_ready"}, 32'(ret_ready), 0);
    chk({tag, "_outst"}, 32'(outstanding), 0);
    chk({tag, "_err"}, 32'(ret_err), 0);
  endtask

  task automatic do_reset();
    req = '0; ret_valid = '0; force_full = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_init();
  endtask

  task automatic rand_inputs();
    req = 4'($urandom_range(0, 15));
    ret_valid = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    ret_tag0 = 6'($urandom_range(0, 63));
    ret_tag1 = 6'($urandom_range(0, 63));
    force_full = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int n;
    bit seen;
    #1 rst = 1'b1;
    @(negedge clk);
    do_reset();

    req = 4'b0001;
    repeat (8) run_cycle();
    chk("single_outst", 32'(outstanding), 4);

    req = 4'b1111;
    repeat (8) run_cycle();

    repeat (400) begin
      rand_inputs();
      run_cycle();
    end

    do_reset();
    req = 4'b1111;
    n = 0;
    while (fq.size() > 0 && n < 200) begin
      run_cycle();
      n++;
    end
    chk("drain_bound", 32'(n < 200), 1);
    repeat (2) run_cycle();
    chk("drain_outst", 32'(outstanding), 64);
    ret_valid = 2'b01; ret_tag0 = 6'd5;
    run_cycle();
    ret_valid = '0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (alloc_valid && alloc_tag == 6'd5) seen = 1;
      run_cycle();
    end
    chk("tag5_delivered", 32'(seen), 1);
    chk("tag5_outst", 32'(outstanding), 64);

    req = '0;
    run_cycle();
    ret_valid = 2'b11; ret_tag0 = 6'd10; ret_tag1 = 6'd11;
    run_cycle();
    ret_valid = '0;
    chk("dual_outst", 32'(outstanding), 62);
    repeat (4) run_cycle();

    force_full = 1'b1;
    ret_valid = 2'b11;
    ret_tag0 = 6'd20; ret_tag1 = 6'd21;
    run_cycle();
    ret_tag0 = 6'd22; ret_tag1 = 6'd23;
    run_cycle();
    chk("bp_ready", 32'(ret_ready), 0);
    chk("bp_err_before", 32'(ret_err), 0);
    ret_tag0 = 6'd24; ret_tag1 = 6'd25;
    run_cycle();
    ret_valid = '0;
    chk("bp_err", 32'(ret_err), 1);
    chk("bp_outst", 32'(outstanding), 58);
    force_full = 1'b0;
    repeat (8) run_cycle();

    do_reset();
    run_cycle();
    ret_valid = 2'b01; ret_tag0 = 6'd7;
    run_cycle();
    ret_valid = '0;
    chk("uflow_err", 32'(ret_err), 1);
    chk("uflow_outst", 32'(outstanding), 0);

    req = 4'b1111;
    repeat (3) run_cycle();
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_init();
    repeat (50) begin
      rand_inputs();
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
